// File: rtl/dict_wr_ctrl_if.sv
// Bundle between the compressor, the dictionary write controller and the dictionary.
// master: compressor/matcher side, drives lane words, stall and clear.
// slave:  dict_wr_ctrl, drives ready, dictionary write controls, pointer mirror,
//         valid mask, count and statistics counters.
interface dict_wr_ctrl_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_ENTRY = 16
);
  localparam int unsigned PtrW = $clog2(WORDS_PER_ENTRY);

  logic                       i_valid0;
  logic [DATA_WIDTH-1:0]      i_data0;
  logic                       i_valid1;
  logic [DATA_WIDTH-1:0]      i_data1;
  logic                       o_ready;
  logic                       i_stall;
  logic                       i_clear;
  logic                       o_wr;
  logic                       o_wr2;
  logic [DATA_WIDTH-1:0]      o_w_data;
  logic [DATA_WIDTH-1:0]      o_w_data2;
  logic [PtrW-1:0]            o_ptr;
  logic [WORDS_PER_ENTRY-1:0] o_valid_mask;
  logic [PtrW:0]              o_count;
  logic [31:0]                o_words_written;
  logic [15:0]                o_wrap_count;
  logic [15:0]                o_split_count;

  modport master (
    output i_valid0, i_data0, i_valid1, i_data1, i_stall, i_clear,
    input  o_ready, o_wr, o_wr2, o_w_data, o_w_data2, o_ptr, o_valid_mask, o_count,
           o_words_written, o_wrap_count, o_split_count
  );

  modport slave (
    input  i_valid0, i_data0, i_valid1, i_data1, i_stall, i_clear,
    output o_ready, o_wr, o_wr2, o_w_data, o_w_data2, o_ptr, o_valid_mask, o_count,
           o_words_written, o_wrap_count, o_split_count
  );
endinterface

// File: rtl/dict_wr_ctrl.sv
// Write controller for the compression dictionary buffer.
// Accepts up to two literal words per cycle (lane0 older), issues registered
// wr/wr2/w_data/w_data2 to the dictionary, mirrors its word pointer and tracks
// which dictionary words hold written data (valid mask + popcount).
// Ports: i_clk, i_reset (async, active-high), bus (dict_wr_ctrl_if.slave).
// Optional statistics counters are built when DICT_CTRL_STATS_EN is defined;
// otherwise the statistics ports are tied to 0.
module dict_wr_ctrl #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_ENTRY = 16
) (
  input logic           i_clk,
  input logic           i_reset,
  dict_wr_ctrl_if.slave bus
);
  localparam int unsigned PtrW = $clog2(WORDS_PER_ENTRY);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(WORDS_PER_ENTRY - 1);

  typedef enum logic {StRun, StSplit} state_e;

  state_e                     state;
  logic [DATA_WIDTH-1:0]      hold;
  logic [PtrW-1:0]            ptr_inc;
  logic [PtrW-1:0]            ptr_next;
  logic [PtrW-1:0]            ptr_hi;
  logic                       wrap;
  logic [WORDS_PER_ENTRY-1:0] set_bits;
  logic [WORDS_PER_ENTRY-1:0] new_bits;
  logic [1:0]                 new_cnt;
  logic                       ready;
  logic                       go_split;

  always_comb begin
    ptr_inc = '0;
    if (bus.o_wr) ptr_inc = bus.o_wr2 ? PtrW'(2) : PtrW'(1);
    // Pointer as it stands after any write landing at this edge; acceptance uses it.
    {wrap, ptr_next} = {1'b0, bus.o_ptr} + {1'b0, ptr_inc};
    ptr_hi = bus.o_ptr + PtrW'(1);
    set_bits = '0;
    if (bus.o_wr) begin
      set_bits[bus.o_ptr] = 1'b1;
      if (bus.o_wr2) set_bits[ptr_hi] = 1'b1;
    end
    // Only bits not already set grow the count, so it always equals the popcount.
    new_bits = set_bits & ~bus.o_valid_mask;
    new_cnt  = 2'(new_bits[bus.o_ptr]) + 2'(new_bits[ptr_hi]);
    ready    = (state == StRun) && !bus.i_stall && !bus.i_clear;
    // A dual write at the last word would wrap the dictionary pointer to 0, not 1.
    go_split = ready && bus.i_valid0 && bus.i_valid1 && (ptr_next == LastPtr);
  end

  assign bus.o_ready = ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= StRun;
      hold             <= '0;
      bus.o_wr         <= 1'b0;
      bus.o_wr2        <= 1'b0;
      bus.o_w_data     <= '0;
      bus.o_w_data2    <= '0;
      bus.o_ptr        <= '0;
      bus.o_valid_mask <= '0;
      bus.o_count      <= '0;
    end else begin
      // A write presented this cycle always lands, even under clear or stall.
      bus.o_ptr <= ptr_next;
      if (bus.i_clear) begin
        bus.o_valid_mask <= '0;
        bus.o_count      <= '0;
      end else begin
        bus.o_valid_mask <= bus.o_valid_mask | set_bits;
        bus.o_count      <= bus.o_count + CntW'(new_cnt);
      end

      bus.o_wr      <= 1'b0;
      bus.o_wr2     <= 1'b0;
      bus.o_w_data  <= '0;
      bus.o_w_data2 <= '0;

      if (bus.i_clear) begin
        state <= StRun;
        hold  <= '0;
      end else if (!bus.i_stall) begin
        unique case (state)
          StRun: begin
            if (go_split) begin
              bus.o_wr     <= 1'b1;
              bus.o_w_data <= bus.i_data0;
              hold         <= bus.i_data1;
              state        <= StSplit;
            end else if (bus.i_valid0 && bus.i_valid1) begin
              bus.o_wr      <= 1'b1;
              bus.o_wr2     <= 1'b1;
              bus.o_w_data  <= bus.i_data0;
              bus.o_w_data2 <= bus.i_data1;
            end else if (bus.i_valid0) begin
              bus.o_wr     <= 1'b1;
              bus.o_w_data <= bus.i_data0;
            end else if (bus.i_valid1) begin
              bus.o_wr     <= 1'b1;
              bus.o_w_data <= bus.i_data1;
            end
          end
          StSplit: begin
            bus.o_wr     <= 1'b1;
            bus.o_w_data <= hold;
            state        <= StRun;
          end
          default: state <= StRun;
        endcase
      end
    end
  end

`ifdef DICT_CTRL_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_words_written <= '0;
      bus.o_wrap_count    <= '0;
      bus.o_split_count   <= '0;
    end else begin
      bus.o_words_written <= bus.o_words_written + 32'(ptr_inc);
      bus.o_wrap_count    <= bus.o_wrap_count + 16'(wrap);
      bus.o_split_count   <= bus.o_split_count + 16'(go_split);
    end
  end
`else
  assign bus.o_words_written = '0;
  assign bus.o_wrap_count    = '0;
  assign bus.o_split_count   = '0;
`endif
endmodule
